// File: rtl/projectile_pool.sv
// projectile_pool
// ---------------------------------------------------------------------------
// Manages a pool of NUM_PROJ projectile slots for one shooter. A fire request
// seen during a frame spawns a shot at the shooter position on the next frame
// tick, if the cooldown has expired and a slot is free. Active shots move by
// X_STEP once per frame and retire on leaving [X_MIN, X_MAX] or on hitting the
// target box. The current pixel ownership flag feeds the color mapper.
//
// Valid/ready: this block has no handshakes. Fire is a level whose rising
// edge latches a request for the current frame; all state changes happen only
// in the single Clk cycle where the synchronised frame tick is high.
//
// Ports:
//   Clk            system clock
//   Reset          asynchronous, active-high reset
//   frame_clk      VGA_VS; rising edge marks a frame
//   Fire           fire request level (rising edge counts)
//   Dir            direction of a new shot: 0 = +X, 1 = -X
//   Shooter_X/Y    spawn position (sampled in the tick cycle)
//   Target_X/Y     target centre (sampled in the tick cycle)
//   Target_Half_W  hit half-width used for both axes
//   DrawX/Y        current pixel
//   is_proj        current pixel lies inside an active projectile
//   hit_pulse      one-Clk pulse after a tick with at least one hit
//   hit_count      saturating total hits since reset
//   active_count   number of active slots
// ---------------------------------------------------------------------------
module projectile_pool #(
    parameter int NUM_PROJ        = 4,
    parameter int X_STEP          = 4,
    parameter int PROJ_SIZE       = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 639
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       Fire,
    input  logic       Dir,
    input  logic [9:0] Shooter_X,
    input  logic [9:0] Shooter_Y,
    input  logic [9:0] Target_X,
    input  logic [9:0] Target_Y,
    input  logic [9:0] Target_Half_W,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       is_proj,
    output logic       hit_pulse,
    output logic [7:0] hit_count,
    output logic [3:0] active_count
);

    localparam logic [10:0] STEP      = 11'(X_STEP);
    localparam logic [10:0] LEFT_LIM  = 11'(X_MIN + X_STEP);
    localparam logic [10:0] RIGHT_LIM = 11'(X_MAX);
    localparam logic [10:0] SIZE_M1   = 11'(PROJ_SIZE - 1);
    localparam logic [7:0]  CD_LOAD   = 8'(COOLDOWN_FRAMES);

    // frame_clk synchroniser, edge register and registered tick
    logic vs_s1_q, vs_s2_q, vs_s3_q, tick_q;

    logic                fire_prev_q, fire_edge;
    logic                fire_pend_q, fire_pend_d;
    logic [7:0]          cd_q, cd_d;
    logic [NUM_PROJ-1:0] act_q, act_d;
    logic [NUM_PROJ-1:0] dir_q, dir_d;
    logic [9:0]          x_q [NUM_PROJ];
    logic [9:0]          x_d [NUM_PROJ];
    logic [9:0]          y_q [NUM_PROJ];
    logic [9:0]          y_d [NUM_PROJ];
    logic [7:0]          hit_count_q, hit_count_d;
    logic                hit_pulse_q, hit_pulse_d;
    logic [3:0]          active_count_q, active_count_d;

    assign fire_edge = Fire & ~fire_prev_q;

    always_comb begin : next_state
        logic [10:0] cur_x, mov_x, dx, dy, tx, ty, hw;
        logic [3:0]  hits;
        logic        spawned;
        logic [8:0]  hit_sum;
        act_d       = act_q;
        dir_d       = dir_q;
        x_d         = x_q;
        y_d         = y_q;
        cd_d        = cd_q;
        hit_count_d = hit_count_q;
        hit_pulse_d = 1'b0;
        cur_x       = '0;
        mov_x       = '0;
        dx          = '0;
        dy          = '0;
        tx          = {1'b0, Target_X};
        ty          = {1'b0, Target_Y};
        hw          = {1'b0, Target_Half_W};
        hits        = '0;
        spawned     = 1'b0;
        hit_sum     = '0;
        // An edge landing in the tick cycle itself belongs to the next frame.
        fire_pend_d = (tick_q ? 1'b0 : fire_pend_q) | fire_edge;

        if (tick_q) begin
            // Move, then hit-test on the moved position.
            for (int i = 0; i < NUM_PROJ; i++) begin
                if (act_q[i]) begin
                    cur_x = {1'b0, x_q[i]};
                    if (dir_q[i]) begin
                        if (cur_x < LEFT_LIM) act_d[i] = 1'b0;
                        else                  mov_x    = cur_x - STEP;
                    end else begin
                        if (cur_x + STEP > RIGHT_LIM) act_d[i] = 1'b0;
                        else                          mov_x    = cur_x + STEP;
                    end
                    if (act_d[i]) begin
                        x_d[i] = mov_x[9:0];
                        dx = (mov_x >= tx) ? (mov_x - tx) : (tx - mov_x);
                        dy = ({1'b0, y_q[i]} >= ty) ? ({1'b0, y_q[i]} - ty)
                                                    : (ty - {1'b0, y_q[i]});
                        if (dx <= hw && dy <= hw) begin
                            act_d[i] = 1'b0;
                            hits     = hits + 4'd1;
                        end
                    end
                end
            end

            hit_sum     = {1'b0, hit_count_q} + {5'b0, hits};
            hit_count_d = hit_sum[8] ? 8'hFF : hit_sum[7:0];
            hit_pulse_d = (hits != 4'd0);

            if (cd_q != 8'd0) cd_d = cd_q - 8'd1;

            // Spawn uses the pre-decrement cooldown and slots freed above.
            if (fire_pend_q && cd_q == 8'd0) begin
                for (int i = 0; i < NUM_PROJ; i++) begin
                    if (!spawned && !act_d[i]) begin
                        act_d[i] = 1'b1;
                        x_d[i]   = Shooter_X;
                        y_d[i]   = Shooter_Y;
                        dir_d[i] = Dir;
                        spawned  = 1'b1;
                    end
                end
                if (spawned) cd_d = CD_LOAD;
            end
        end
    end

    always_comb begin
        active_count_d = '0;
        for (int i = 0; i < NUM_PROJ; i++) begin
            active_count_d = active_count_d + {3'b000, act_d[i]};
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vs_s1_q        <= 1'b0;
            vs_s2_q        <= 1'b0;
            vs_s3_q        <= 1'b0;
            tick_q         <= 1'b0;
            fire_prev_q    <= 1'b0;
            fire_pend_q    <= 1'b0;
            cd_q           <= '0;
            act_q          <= '0;
            dir_q          <= '0;
            hit_count_q    <= '0;
            hit_pulse_q    <= 1'b0;
            active_count_q <= '0;
            for (int i = 0; i < NUM_PROJ; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            vs_s1_q        <= frame_clk;
            vs_s2_q        <= vs_s1_q;
            vs_s3_q        <= vs_s2_q;
            tick_q         <= vs_s2_q & ~vs_s3_q;
            fire_prev_q    <= Fire;
            fire_pend_q    <= fire_pend_d;
            cd_q           <= cd_d;
            act_q          <= act_d;
            dir_q          <= dir_d;
            hit_count_q    <= hit_count_d;
            hit_pulse_q    <= hit_pulse_d;
            active_count_q <= active_count_d;
            for (int i = 0; i < NUM_PROJ; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    // Pixel ownership: widened compares so X+PROJ_SIZE-1 cannot wrap.
    always_comb begin
        is_proj = 1'b0;
        for (int i = 0; i < NUM_PROJ; i++) begin
            if (act_q[i] &&
                {1'b0, DrawX} >= {1'b0, x_q[i]} && {1'b0, DrawX} <= {1'b0, x_q[i]} + SIZE_M1 &&
                {1'b0, DrawY} >= {1'b0, y_q[i]} && {1'b0, DrawY} <= {1'b0, y_q[i]} + SIZE_M1)
                is_proj = 1'b1;
        end
    end

    assign hit_pulse    = hit_pulse_q;
    assign hit_count    = hit_count_q;
    assign active_count = active_count_q;

endmodule
